// File: rtl/zap_div_pkg.sv
// Shared definitions for the ZAP multi-cycle divider: divide opcodes,
// FSM state encodings and the iteration count.
package zap_div_pkg;

    // Divide opcodes within the common ALU opcode space
    localparam int unsigned UDIV = 26;
    localparam int unsigned SDIV = 27;
    localparam int unsigned UREM = 28;
    localparam int unsigned SREM = 29;

    // One quotient bit per iteration for a 32-bit result
    localparam int unsigned ITER_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/zap_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the result when
// it is non-negative and shift the resulting quotient bit into dvd.
module zap_div_step
    import zap_div_pkg::*;
(
    input  logic [32:0] r_in,
    input  logic [31:0] dvd_in,
    input  logic [31:0] dvs,
    output logic [32:0] r_out,
    output logic [31:0] dvd_out
);

    logic [32:0] shifted;
    logic [32:0] trial;
    logic        q_bit;

    // The remainder stays below the divisor, so its top bit never carries
    // information into the next step.
    logic unused_r_msb;
    assign unused_r_msb = r_in[32];

    // Trial subtraction and restore decision
    always_comb begin
        shifted = {r_in[31:0], dvd_in[31]};
        trial   = shifted - {1'b0, dvs};
        q_bit   = ~trial[32];
        r_out   = q_bit ? trial : shifted;
        dvd_out = {dvd_in[30:0], q_bit};
    end

endmodule

// File: rtl/zap_divide.sv
// ZAP multi-cycle integer divider. Computes a 32-bit quotient or remainder,
// signed or unsigned, one quotient bit per cycle, using the same busy /
// stall / clear contract as the multi-cycle multiplier.
module zap_divide
    import zap_div_pkg::*;
#(
    parameter int PHY_REGS = 46,
    parameter int ALU_OPS  = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_clear_from_writeback,
    input  logic                       i_data_stall,
    input  logic                       i_clear_from_alu,
    input  logic [$clog2(ALU_OPS)-1:0] i_alu_operation_ff,
    input  logic                       i_cc_satisfied,
    input  logic [31:0]                i_rm,
    input  logic [31:0]                i_rs,
    output logic [31:0]                o_rd,
    output logic                       o_busy,
    output logic                       o_dbz
);

    localparam int OP_W = $clog2(ALU_OPS);

    // Register-file size is carried only so all ALU units share one
    // instantiation template.
    localparam int unused_phy_regs = PHY_REGS;

    div_state_t  state;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [32:0] rem_acc;
    logic [4:0]  count;
    logic        qneg;
    logic        rneg;
    logic        op_sign;
    logic        op_rem;
    logic        dbz;

    logic        dec_sign;
    logic        dec_rem;
    logic        dec_div;
    logic        start;
    logic        flush;
    logic [32:0] rem_next;
    logic [31:0] dvd_next;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Two's-complement magnitude of a signed 32-bit value
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // Conditional negation used by the sign fix-up
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Opcode decode and start / flush qualification
    always_comb begin
        dec_sign = (i_alu_operation_ff == OP_W'(SDIV)) || (i_alu_operation_ff == OP_W'(SREM));
        dec_rem  = (i_alu_operation_ff == OP_W'(UREM)) || (i_alu_operation_ff == OP_W'(SREM));
        dec_div  = (i_alu_operation_ff == OP_W'(UDIV)) || (i_alu_operation_ff == OP_W'(SDIV)) ||
                   dec_rem;
        start    = i_cc_satisfied && dec_div;
        // Writeback clear beats the stall; ALU clear only acts when not stalled
        flush    = i_clear_from_writeback || (!i_data_stall && i_clear_from_alu);
    end

    zap_div_step u_step (
        .r_in    (rem_acc),
        .dvd_in  (dvd),
        .dvs     (dvs),
        .r_out   (rem_next),
        .dvd_out (dvd_next)
    );

    // Divider FSM: accept, magnitude preparation, 32 restoring steps, result
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            dvd     <= '0;
            dvs     <= '0;
            rem_acc <= '0;
            count   <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            op_sign <= 1'b0;
            op_rem  <= 1'b0;
            dbz     <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            dvd     <= '0;
            dvs     <= '0;
            rem_acc <= '0;
            count   <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            op_sign <= 1'b0;
            op_rem  <= 1'b0;
            dbz     <= 1'b0;
        end else if (!i_data_stall) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= PREP;
                        op_sign <= dec_sign;
                        op_rem  <= dec_rem;
                    end
                end
                PREP: begin
                    count <= 5'(ITER_COUNT - 1);
                    dvs   <= op_sign ? abs32(i_rs) : i_rs;
                    if (i_rs == 32'd0) begin
                        // Quotient 0 and the raw dividend as remainder, no sign fix-up
                        state   <= DONE;
                        dvd     <= '0;
                        rem_acc <= {1'b0, i_rm};
                        qneg    <= 1'b0;
                        rneg    <= 1'b0;
                        dbz     <= 1'b1;
                    end else begin
                        state   <= ITER;
                        dvd     <= op_sign ? abs32(i_rm) : i_rm;
                        rem_acc <= '0;
                        qneg    <= op_sign & (i_rm[31] ^ i_rs[31]);
                        rneg    <= op_sign & i_rm[31];
                        dbz     <= 1'b0;
                    end
                end
                ITER: begin
                    rem_acc <= rem_next;
                    dvd     <= dvd_next;
                    count   <= count - 5'd1;
                    if (count == 5'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sign fix-up and result / status outputs
    always_comb begin
        quot_fix = neg_if(qneg, dvd);
        rem_fix  = neg_if(rneg, rem_acc[31:0]);
        o_busy   = ((state == IDLE) && start) || (state == PREP) || (state == ITER);
        o_rd     = '0;
        o_dbz    = 1'b0;
        if (state == DONE) begin
            o_rd  = op_rem ? rem_fix : quot_fix;
            o_dbz = dbz;
        end
    end

endmodule

// File: tb/tb_zap_divide.sv
// Directed bench for zap_divide: results, latency, divide by zero,
// stalls, clears and asynchronous reset.
module tb_zap_divide;
    import zap_div_pkg::*;

    localparam logic [4:0] NOP = 5'd0;
    localparam logic [4:0] OP_UDIV = 5'(UDIV);
    localparam logic [4:0] OP_SDIV = 5'(SDIV);
    localparam logic [4:0] OP_UREM = 5'(UREM);
    localparam logic [4:0] OP_SREM = 5'(SREM);

    logic        clk;
    logic        rst_n;
    logic        clr_wb;
    logic        stall;
    logic        clr_alu;
    logic [4:0]  op;
    logic        cc;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] o_rd;
    logic        o_busy;
    logic        o_dbz;

    int total = 0;
    int bad   = 0;

    zap_divide #(.PHY_REGS(46), .ALU_OPS(32)) dut (
        .i_clk                  (clk),
        .i_reset_n              (rst_n),
        .i_clear_from_writeback (clr_wb),
        .i_data_stall           (stall),
        .i_clear_from_alu       (clr_alu),
        .i_alu_operation_ff     (op),
        .i_cc_satisfied         (cc),
        .i_rm                   (rm),
        .i_rs                   (rs),
        .o_rd                   (o_rd),
        .o_busy                 (o_busy),
        .o_dbz                  (o_dbz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive a divide request for one accept cycle; returns in PREP, 1 cycle after accept
    task automatic launch(input logic [4:0] op_v, input logic [31:0] a, input logic [31:0] b,
                          output logic acc_busy);
        op = op_v; cc = 1'b1; rm = a; rs = b;
        #1 acc_busy = o_busy;
        @(posedge clk); #1;
        op = NOP; cc = 1'b0;
    endtask

    // Advance until busy drops; n counts cycles since the accept cycle
    task automatic wait_idle(input int start_n, output int n);
        n = start_n;
        while (o_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        total++; if (o_rd !== 32'd0) begin bad++; $display("FAIL reset_rd: got %h want %h", o_rd, 32'd0); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        total++; if (o_dbz !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", o_dbz); end
    endtask

    task automatic test_unsigned();
        logic ab; int n;
        launch(OP_UDIV, 32'd100, 32'd7, ab);
        total++; if (ab !== 1'b1) begin bad++; $display("FAIL udiv_accept_busy: got %b want 1", ab); end
        wait_idle(1, n);
        total++; if (n != 34) begin bad++; $display("FAIL udiv_latency: got %0d want 34", n); end
        total++; if (o_rd !== 32'h0000000E) begin bad++; $display("FAIL udiv_100_7: got %h want %h", o_rd, 32'h0000000E); end
        total++; if (o_dbz !== 1'b0) begin bad++; $display("FAIL udiv_dbz: got %b want 0", o_dbz); end
        @(posedge clk); #1;
        launch(OP_UREM, 32'd100, 32'd7, ab);
        wait_idle(1, n);
        total++; if (o_rd !== 32'd2) begin bad++; $display("FAIL urem_100_7: got %h want %h", o_rd, 32'd2); end
        @(posedge clk); #1;
        launch(OP_UDIV, 32'hFFFFFFFF, 32'd1, ab);
        wait_idle(1, n);
        total++; if (o_rd !== 32'hFFFFFFFF) begin bad++; $display("FAIL udiv_max_1: got %h want %h", o_rd, 32'hFFFFFFFF); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed();
        logic ab; int n;
        logic [4:0]  ops [5] = '{OP_SDIV, OP_SREM, OP_SREM, OP_SDIV, OP_SREM};
        logic [31:0] as  [5] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'd0};
        for (int i = 0; i < 5; i++) begin
            launch(ops[i], as[i], bs[i], ab);
            wait_idle(1, n);
            total++;
            if (o_rd !== exp[i]) begin
                bad++;
                $display("FAIL signed_vec%0d: got %h want %h", i, o_rd, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        logic ab; int n;
        launch(OP_UDIV, 32'd5, 32'd0, ab);
        wait_idle(1, n);
        total++; if (n != 2) begin bad++; $display("FAIL dbz_latency: got %0d want 2", n); end
        total++; if (o_rd !== 32'd0) begin bad++; $display("FAIL dbz_quot: got %h want %h", o_rd, 32'd0); end
        total++; if (o_dbz !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", o_dbz); end
        @(posedge clk); #1;
        total++; if (o_dbz !== 1'b0) begin bad++; $display("FAIL dbz_flag_idle: got %b want 0", o_dbz); end
        launch(OP_UREM, 32'd5, 32'd0, ab);
        wait_idle(1, n);
        total++; if (o_rd !== 32'd5) begin bad++; $display("FAIL dbz_urem: got %h want %h", o_rd, 32'd5); end
        @(posedge clk); #1;
        launch(OP_SREM, 32'hFFFFFFFB, 32'd0, ab);
        wait_idle(1, n);
        total++; if (o_rd !== 32'hFFFFFFFB) begin bad++; $display("FAIL dbz_srem: got %h want %h", o_rd, 32'hFFFFFFFB); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_iter();
        logic ab; int n;
        launch(OP_UDIV, 32'd1000, 32'd3, ab);
        repeat (5) begin @(posedge clk); #1; end
        stall = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        stall = 1'b0;
        wait_idle(11, n);
        total++; if (n != 39) begin bad++; $display("FAIL stall_iter_latency: got %0d want 39", n); end
        total++; if (o_rd !== 32'd333) begin bad++; $display("FAIL stall_iter_result: got %h want %h", o_rd, 32'd333); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_done();
        logic ab; int n; int errs;
        launch(OP_UREM, 32'd1000, 32'd7, ab);
        wait_idle(1, n);
        stall = 1'b1;
        errs = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (o_rd !== 32'd6 || o_busy !== 1'b0) errs++;
        end
        stall = 1'b0;
        total++; if (errs != 0) begin bad++; $display("FAIL stall_done_hold: got %0d bad cycles want 0 (last rd %h busy %b)", errs, o_rd, o_busy); end
        @(posedge clk); #1;
        total++; if (o_rd !== 32'd0) begin bad++; $display("FAIL stall_done_release: got %h want %h", o_rd, 32'd0); end
    endtask

    task automatic test_clear_alu();
        logic ab; int errs;
        launch(OP_UDIV, 32'd100, 32'd7, ab);
        repeat (10) begin @(posedge clk); #1; end
        clr_alu = 1'b1;
        @(posedge clk); #1;
        clr_alu = 1'b0;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL clear_alu_busy: got %b want 0", o_busy); end
        errs = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (o_busy !== 1'b0 || o_rd !== 32'd0 || o_dbz !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL clear_alu_no_result: got %0d bad cycles want 0", errs); end
    endtask

    task automatic test_clear_wb_stall();
        logic ab;
        launch(OP_SDIV, 32'd50, 32'd5, ab);
        repeat (3) begin @(posedge clk); #1; end
        clr_wb = 1'b1; stall = 1'b1;
        @(posedge clk); #1;
        clr_wb = 1'b0; stall = 1'b0;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL clear_wb_over_stall: got %b want 0", o_busy); end
        @(posedge clk); #1;
        total++; if (o_busy !== 1'b0 || o_rd !== 32'd0) begin bad++; $display("FAIL clear_wb_idle: got busy %b rd %h want 0 0", o_busy, o_rd); end
    endtask

    task automatic test_reset_midop();
        logic ab; int n;
        launch(OP_UDIV, 32'd100, 32'd7, ab);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %b want 0", o_busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        launch(OP_UREM, 32'd9, 32'd0, ab);
        wait_idle(1, n);
        #2 rst_n = 1'b0;
        #1;
        total++; if (o_rd !== 32'd0 || o_dbz !== 1'b0) begin bad++; $display("FAIL reset_in_done: got rd %h dbz %b want 0 0", o_rd, o_dbz); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_non_divide();
        op = 5'd3; cc = 1'b1; rm = 32'd10; rs = 32'd2;
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL nondiv_busy: got %b want 0", o_busy); end
        @(posedge clk); #1;
        op = OP_UDIV; cc = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL nocc_busy: got %b want 0", o_busy); end
        @(posedge clk); #1;
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL nocc_stays_idle: got %b want 0", o_busy); end
        op = NOP;
    endtask

    task automatic test_back_to_back();
        logic ab; int n;
        launch(OP_UDIV, 32'd81, 32'd9, ab);
        wait_idle(1, n);
        total++; if (o_rd !== 32'd9) begin bad++; $display("FAIL b2b_first: got %h want %h", o_rd, 32'd9); end
        @(posedge clk); #1;
        launch(OP_UREM, 32'd81, 32'd10, ab);
        total++; if (ab !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", ab); end
        wait_idle(1, n);
        total++; if (n != 34 || o_rd !== 32'd1) begin bad++; $display("FAIL b2b_second: got n=%0d rd=%h want n=34 rd=%h", n, o_rd, 32'd1); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; clr_wb = 1'b0; stall = 1'b0; clr_alu = 1'b0;
        op = NOP; cc = 1'b0; rm = '0; rs = '0;
        #2;
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_unsigned();
        test_signed();
        test_div_zero();
        test_stall_iter();
        test_stall_done();
        test_clear_alu();
        test_clear_wb_stall();
        test_reset_midop();
        test_non_divide();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zap_divide.md
# zap_divide

Multi-cycle integer divider for the ZAP ALU stage, the inverse of the existing multi-cycle multiply path. It computes a 32-bit quotient or remainder, signed or unsigned, with a radix-2 restoring algorithm, one quotient bit per cycle. It sits beside the multiplier under the ALU and uses the same control contract. It raises `o_busy` while iterating, so the pipeline holds the operands, and it honours the writeback/ALU clears and the data stall.

## Interface
- `PHY_REGS`, 46, physical register count (pass-through, kept for a uniform instantiation)
- `ALU_OPS`, 32, ALU opcode space; sets the width of `i_alu_operation_ff`
- `i_clk`  in  1  clock
- `i_reset_n`  in  1  reset, asynchronous, active-low
- `i_clear_from_writeback`  in  1  synchronous flush, highest priority after reset
- `i_data_stall`  in  1  hold all state
- `i_clear_from_alu`  in  1  synchronous flush, lower priority than the stall
- `i_alu_operation_ff`  in  $clog2(ALU_OPS)  opcode; the block is active for UDIV, SDIV, UREM, SREM
- `i_cc_satisfied`  in  1  condition passed; required to start
- `i_rm`  in  32  dividend; stable while `o_busy` is high
- `i_rs`  in  32  divisor; stable while `o_busy` is high
- `o_rd`  out  32  result; valid only in DONE, 0 otherwise
- `o_busy`  out  1  unit busy
- `o_dbz`  out  1  divide-by-zero flag; valid only in DONE

## Operation
- **Opcode decode**
  - sign = op ∈ {SDIV, SREM}
  - rem = op ∈ {UREM, SREM}
- **States:** IDLE, PREP, ITER, DONE.
- **IDLE**
  - `o_busy` = 0 unless starting.
  - Start when `i_cc_satisfied` is high and the op is a divide op. On start, `o_busy` = 1 combinationally and the next state is PREP.
- **PREP**
  - Latch `dvd` = sign ? |rm| : rm and `dvs` = sign ? |rs| : rs, both as 32-bit unsigned.
  - Latch `qneg` = sign & (rm[31]^rs[31]) and `rneg` = sign & rm[31].
  - Clear the 33-bit partial remainder R and set count = 31.
  - If rs == 0, the next state is DONE and ITER is skipped. Otherwise the next state is ITER.
- **ITER** (one step per cycle)
  - T = {R[31:0], dvd[31]} − {1'b0, dvs}.
  - If T is non-negative, R = T and the quotient bit is 1. Otherwise R = {R[31:0], dvd[31]} and the quotient bit is 0.
  - Shift dvd left by one with the quotient bit entering at LSB, so dvd becomes Q.
  - Decrement count. Leave for DONE after the step with count == 0, which gives 32 steps.
- **DONE**
  - `o_busy` = 0 and the next state is IDLE.
  - Q' = qneg ? −Q : Q; R' = rneg ? −R[31:0] : R[31:0]. Both are computed combinationally.
  - `o_rd` = rem ? R' : Q'.
- **Divide by zero**
  - Quotient = 0, remainder = dividend (`i_rm` unmodified), `o_dbz` = 1.
  - `o_dbz` = 0 in every other case.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the magnitude path with no special case.
- **Rounding:** quotient truncates toward zero; the remainder takes the sign of the dividend.

## Timing
- **Reset:** asynchronous (`i_reset_n` low) forces state = IDLE and clears dvd, dvs, R, count and the sign flags. Outputs then read `o_rd` = 0, `o_busy` = 0, `o_dbz` = 0.
- **Latency, normal divide:** accept cycle (IDLE) → PREP → 32 × ITER → DONE. The result appears 34 cycles after the accept cycle, with `o_busy` high for the 34 cycles from accept through the last ITER.
- **Latency, divide by zero:** accept → PREP → DONE, so the result appears 2 cycles after accept.
- **DONE is a single cycle.** A back-to-back divide in the next cycle is accepted from IDLE, which gives one idle cycle between ops.
- **Priority on each clock edge:**
  1. `i_clear_from_writeback` forces IDLE and clears state.
  2. `i_data_stall` holds everything, including DONE: combinational outputs stay stable and DONE repeats.
  3. `i_clear_from_alu` forces IDLE and clears state.
  4. Otherwise the state advances.
- **Clear mid-operation:** the block is in IDLE on the next cycle with `o_busy` = 0 and no result is produced.
- **Reset mid-operation:** IDLE immediately (asynchronous).
- **Non-divide opcodes in IDLE:** the state is unchanged and `o_busy` stays 0.

## Structure
- **Shared package `zap_div_pkg`:**
  - opcode constants UDIV, SDIV, UREM, SREM, added to the common opcode list
  - state encodings IDLE = 0, PREP = 1, ITER = 2, DONE = 3
  - ITER_COUNT = 32
- **Sub-module `zap_div_step`:** purely combinational, one restoring step. Inputs are R[32:0], dvd[31:0] and dvs[31:0]; outputs are the next R and the next dvd.
- **Top:** FSM, the 5-bit counter, sign latches and the output fix-up mux.

## Test plan
- UDIV 100/7 → at DONE (34 cycles after accept): `o_rd` = 14 (0x0000000E), `o_busy` = 0, `o_dbz` = 0. UREM 100/7 → `o_rd` = 2.
- SDIV −7/2 (0xFFFFFFF9, 0x00000002) → 0xFFFFFFFD (−3). SREM → 0xFFFFFFFF (−1). SREM 7/−2 → 1.
- SDIV 0x80000000/0xFFFFFFFF → 0x80000000. UDIV 0xFFFFFFFF/1 → 0xFFFFFFFF.
- UDIV 5/0 → DONE 2 cycles after accept, `o_rd` = 0, `o_dbz` = 1. UREM 5/0 → `o_rd` = 5.
- Stall:
  - Assert `i_data_stall` for 5 cycles mid-ITER → result at cycle 39 and still correct.
  - Stall in DONE → `o_rd` held and `o_busy` = 0 for every stalled cycle.
- Clears and reset:
  - `i_clear_from_alu` at ITER step 10 → IDLE next cycle, `o_busy` = 0.
  - `i_clear_from_writeback` together with `i_data_stall` → clear wins.
  - `i_reset_n` low mid-op → all outputs 0 without waiting for a clock edge.
